int2fp_conv: RTL



---
 rtl/int2fp_conv.sv | 114 +++++++++++
 1 files changed

// File: rtl/int2fp_conv.sv
// int2fp_conv: multi-cycle 32-bit integer to IEEE-754 single-precision converter.
// Normalizes one bit per cycle, then rounds to nearest-even. A start/busy/done
// handshake frames each conversion; c and inexact hold until the next done.
module int2fp_conv #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [31:0] c,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t      state;
    logic        sign;
    logic [31:0] mag;
    logic [8:0]  exp;

    // Operand preparation and rounding datapath.
    logic        a_neg;
    logic [31:0] a_mag;
    logic [22:0] m;
    logic        g;
    logic        s;
    logic        rnd_up;
    logic [23:0] m_inc;
    logic [8:0]  exp_rnd;

    // Sign/magnitude of the incoming operand and round-to-nearest-even of the normalized magnitude.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        a_neg   = SIGNED & a[31];
        // -2^31 negates to 0x80000000, which is already the correct unsigned magnitude.
        a_mag   = a_neg ? (~a + 32'd1) : a;
        m       = mag[30:8];
        g       = mag[7];
        s       = |mag[6:0];
        rnd_up  = g & (s | mag[8]);
        m_inc   = {1'b0, m} + {23'd0, rnd_up};
        // A carry out of the mantissa means it was all ones: it wraps to zero and the exponent bumps.
        exp_rnd = exp + {8'd0, m_inc[23]};
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: datapath registers are reset too; they are few and it keeps simulation free of X.
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            c       <= 32'h0000_0000;
            inexact <= 1'b0;
            sign    <= 1'b0;
            mag     <= 32'd0;
            exp     <= 9'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign <= a_neg;
                        mag  <= a_mag;
                        exp  <= 9'd158;
                        if (a_mag == 32'd0) begin
                            // Zero skips normalization and is always +0.
                            state   <= DONE;
                            done    <= 1'b1;
                            c       <= 32'h0000_0000;
                            inexact <= 1'b0;
                        end else begin
                            state <= NORM;
                            busy  <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    if (mag[31]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - 9'd1;
                    end
                end
                ROUND: begin
                    c       <= {sign, exp_rnd[7:0], m_inc[22:0]};
                    inexact <= g | s;
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                DONE: begin
                    // start is deliberately not sampled here; the earliest acceptance is next cycle.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
